// File: rtl/controller_sam_pkg.sv
// Shared definitions for the SAM controller: state encoding, strobe bit
// positions in b, opcode values and the control word for every state.
package controller_sam_pkg;

    typedef enum logic [3:0] {
        S_RST = 4'd0,
        S_F1  = 4'd1,
        S_FRW = 4'd2,
        S_FLT = 4'd3,
        S_F4  = 4'd4,
        S_DEC = 4'd5,
        S_BR  = 4'd6,
        S_RDW = 4'd7,
        S_RDL = 4'd8,
        S_LDX = 4'd9,
        S_ADX = 4'd10,
        S_ST1 = 4'd11,
        S_STW = 4'd12
    } state_t;

    localparam int unsigned BIT_PC_ABUS   = 21;
    localparam int unsigned BIT_IR_ABUS   = 20;
    localparam int unsigned BIT_MBR_ABUS  = 19;
    localparam int unsigned BIT_RBUS_AC   = 18;
    localparam int unsigned BIT_AC_ALUA   = 17;
    localparam int unsigned BIT_MBUS_ALUB = 16;
    localparam int unsigned BIT_ALU_ADD   = 15;
    localparam int unsigned BIT_ALU_PASSB = 14;
    localparam int unsigned BIT_MAR_ADDR  = 13;
    localparam int unsigned BIT_MBR_DATA  = 12;
    localparam int unsigned BIT_ABUS_IR   = 11;
    localparam int unsigned BIT_ABUS_MAR  = 10;
    localparam int unsigned BIT_DATA_MBR  = 9;
    localparam int unsigned BIT_RBUS_MBR  = 8;
    localparam int unsigned BIT_MBR_MBUS  = 7;
    localparam int unsigned BIT_PC_CLR    = 6;
    localparam int unsigned BIT_PC_INC    = 5;
    localparam int unsigned BIT_ABUS_PC   = 4;
    localparam int unsigned BIT_RW        = 3;
    localparam int unsigned BIT_REQUEST   = 2;
    localparam int unsigned BIT_AC_RBUS   = 1;
    localparam int unsigned BIT_ALU_RBUS  = 0;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_BRN   = 2'b11;

    // Control words are assembled from the named strobes so each state's
    // intent is readable; wait states share address/RW with their latch state.
    localparam logic [21:0] BVAL_RST = (22'd1 << BIT_PC_CLR);
    localparam logic [21:0] BVAL_F1  = (22'd1 << BIT_PC_ABUS) | (22'd1 << BIT_ABUS_MAR);
    localparam logic [21:0] BVAL_FRW = (22'd1 << BIT_MAR_ADDR) | (22'd1 << BIT_RW)
                                     | (22'd1 << BIT_REQUEST);
    localparam logic [21:0] BVAL_FLT = (22'd1 << BIT_MAR_ADDR) | (22'd1 << BIT_DATA_MBR)
                                     | (22'd1 << BIT_PC_INC) | (22'd1 << BIT_RW);
    localparam logic [21:0] BVAL_F4  = (22'd1 << BIT_MBR_ABUS) | (22'd1 << BIT_ABUS_IR);
    localparam logic [21:0] BVAL_DEC = (22'd1 << BIT_IR_ABUS) | (22'd1 << BIT_ABUS_MAR);
    localparam logic [21:0] BVAL_BR  = (22'd1 << BIT_IR_ABUS) | (22'd1 << BIT_ABUS_PC);
    localparam logic [21:0] BVAL_RDW = BVAL_FRW;
    localparam logic [21:0] BVAL_RDL = (22'd1 << BIT_MAR_ADDR) | (22'd1 << BIT_DATA_MBR)
                                     | (22'd1 << BIT_RW);
    localparam logic [21:0] BVAL_LDX = (22'd1 << BIT_RBUS_AC) | (22'd1 << BIT_MBUS_ALUB)
                                     | (22'd1 << BIT_ALU_PASSB) | (22'd1 << BIT_MBR_MBUS)
                                     | (22'd1 << BIT_ALU_RBUS);
    localparam logic [21:0] BVAL_ADX = (22'd1 << BIT_RBUS_AC) | (22'd1 << BIT_AC_ALUA)
                                     | (22'd1 << BIT_MBUS_ALUB) | (22'd1 << BIT_ALU_ADD)
                                     | (22'd1 << BIT_MBR_MBUS) | (22'd1 << BIT_ALU_RBUS);
    localparam logic [21:0] BVAL_ST1 = (22'd1 << BIT_RBUS_MBR) | (22'd1 << BIT_AC_RBUS);
    localparam logic [21:0] BVAL_STW = (22'd1 << BIT_MAR_ADDR) | (22'd1 << BIT_MBR_DATA)
                                     | (22'd1 << BIT_REQUEST);

endpackage

// File: rtl/controller_sam.sv
// Moore control unit for the SAM datapath: fetch, decode and the
// LOAD/STORE/ADD/BRN execute sequences, with unbounded memory waits.
module controller_sam
    import controller_sam_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_wait,
    input  logic        ir15,
    input  logic        ac15,
    input  logic        ir14,
    output logic [21:0] b
);

    state_t     state;
    state_t     state_next;
    logic [1:0] opcode;

    assign opcode = {ir15, ir14};

    always_ff @(posedge clk) begin
        if (rst)
            state <= S_RST;
        else
            state <= state_next;
    end

    // mem_wait only matters in the three wait states; the opcode is looked
    // at in DEC and again in RDL to pick the execute step.
    always_comb begin
        state_next = state;
        unique case (state)
            S_RST: state_next = S_F1;
            S_F1:  state_next = S_FRW;
            S_FRW: state_next = mem_wait ? S_FRW : S_FLT;
            S_FLT: state_next = S_F4;
            S_F4:  state_next = S_DEC;
            S_DEC: begin
                unique case (opcode)
                    OP_LOAD, OP_ADD: state_next = S_RDW;
                    OP_STORE:        state_next = S_ST1;
                    default:         state_next = ac15 ? S_BR : S_F1;
                endcase
            end
            S_RDW: state_next = mem_wait ? S_RDW : S_RDL;
            S_RDL: state_next = (opcode == OP_ADD) ? S_ADX : S_LDX;
            S_LDX, S_ADX, S_BR: state_next = S_F1;
            S_ST1: state_next = S_STW;
            S_STW: state_next = mem_wait ? S_STW : S_F1;
            default: state_next = S_RST;
        endcase
    end

    always_comb begin
        b = BVAL_RST;
        unique case (state)
            S_RST: b = BVAL_RST;
            S_F1:  b = BVAL_F1;
            S_FRW: b = BVAL_FRW;
            S_FLT: b = BVAL_FLT;
            S_F4:  b = BVAL_F4;
            S_DEC: b = BVAL_DEC;
            S_BR:  b = BVAL_BR;
            S_RDW: b = BVAL_RDW;
            S_RDL: b = BVAL_RDL;
            S_LDX: b = BVAL_LDX;
            S_ADX: b = BVAL_ADX;
            S_ST1: b = BVAL_ST1;
            S_STW: b = BVAL_STW;
            default: b = BVAL_RST;
        endcase
    end

endmodule

// File: tb/tb_controller_sam.sv
// Self-checking bench for controller_sam: directed instruction sequences
// followed by random instructions with random wait lengths.
module tb_controller_sam;

    localparam logic [21:0] E_RST = 22'h000040;
    localparam logic [21:0] E_F1  = 22'h200400;
    localparam logic [21:0] E_FRW = 22'h00200C;
    localparam logic [21:0] E_FLT = 22'h002228;
    localparam logic [21:0] E_F4  = 22'h080800;
    localparam logic [21:0] E_DEC = 22'h100400;
    localparam logic [21:0] E_BR  = 22'h100010;
    localparam logic [21:0] E_RDW = 22'h00200C;
    localparam logic [21:0] E_RDL = 22'h002208;
    localparam logic [21:0] E_LDX = 22'h054081;
    localparam logic [21:0] E_ADX = 22'h078081;
    localparam logic [21:0] E_ST1 = 22'h000102;
    localparam logic [21:0] E_STW = 22'h003004;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wait;
    logic        ir15;
    logic        ac15;
    logic        ir14;
    logic [21:0] b;

    int total = 0;
    int bad   = 0;

    controller_sam dut (
        .clk      (clk),
        .rst      (rst),
        .mem_wait (mem_wait),
        .ir15     (ir15),
        .ac15     (ac15),
        .ir14     (ir14),
        .b        (b)
    );

    always #5 clk = ~clk;

    // Drive mem_wait for the current cycle, then move one clock past the edge.
    task automatic applyStimulus(input logic mw);
        mem_wait = mw;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input logic [21:0] expected, input string tag);
        total++;
        assert (b === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, b, expected);
        end
    endtask

    // One cycle of the reference sequence: check this cycle's word, then
    // advance with the given mem_wait value.
    task automatic cyc(input logic [21:0] expected, input string tag, input logic mw);
        checkOutput(expected, tag);
        applyStimulus(mw);
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    // Reference model: the control-word sequence of one whole instruction,
    // starting in F1, with wf fetch wait cycles and wm operand wait cycles.
    task automatic runInstr(input logic [1:0] op, input logic ac, input int wf, input int wm);
        {ir15, ir14} = op;
        ac15 = ac;
        cyc(E_F1, "F1", rnd());
        repeat (wf) cyc(E_FRW, "FRW_wait", 1'b1);
        cyc(E_FRW, "FRW_done", 1'b0);
        cyc(E_FLT, "FLT", rnd());
        cyc(E_F4, "F4", rnd());
        cyc(E_DEC, "DEC", rnd());
        case (op)
            2'b00, 2'b10: begin
                repeat (wm) cyc(E_RDW, "RDW_wait", 1'b1);
                cyc(E_RDW, "RDW_done", 1'b0);
                cyc(E_RDL, "RDL", rnd());
                if (op == 2'b00) cyc(E_LDX, "LDX", rnd());
                else             cyc(E_ADX, "ADX", rnd());
            end
            2'b01: begin
                cyc(E_ST1, "ST1", rnd());
                repeat (wm) cyc(E_STW, "STW_wait", 1'b1);
                cyc(E_STW, "STW_done", 1'b0);
            end
            default: begin
                if (ac) cyc(E_BR, "BR", rnd());
            end
        endcase
    endtask

    initial begin
        rst      = 1'b1;
        mem_wait = 1'b0;
        ir15     = 1'b0;
        ir14     = 1'b0;
        ac15     = 1'b0;

        applyStimulus(1'b0);
        checkOutput(E_RST, "reset_edge1");
        applyStimulus(1'b1);
        checkOutput(E_RST, "reset_edge2");
        rst = 1'b0;
        applyStimulus(1'b1);

        // Fetch with a three-cycle wait, then plain LOAD.
        runInstr(2'b00, 1'b0, 3, 0);
        runInstr(2'b00, 1'b0, 0, 0);

        // Reset in the middle of a fetch wait.
        cyc(E_F1, "F1_pre_rst", 1'b0);
        checkOutput(E_FRW, "FRW_pre_rst");
        rst = 1'b1;
        applyStimulus(1'b1);
        checkOutput(E_RST, "rst_midfrw1");
        applyStimulus(1'b1);
        checkOutput(E_RST, "rst_midfrw2");
        rst = 1'b0;
        applyStimulus(1'b1);

        // ADD, STORE with two wait cycles, BRN taken and not taken.
        runInstr(2'b10, 1'b1, 0, 0);
        runInstr(2'b01, 1'b0, 0, 2);
        runInstr(2'b11, 1'b1, 0, 0);
        runInstr(2'b11, 1'b0, 0, 0);
        runInstr(2'b10, 1'b0, 1, 2);

        // Reset in the middle of a store wait.
        ir15 = 1'b0;
        ir14 = 1'b1;
        cyc(E_F1, "F1_st", 1'b0);
        cyc(E_FRW, "FRW_st", 1'b0);
        cyc(E_FLT, "FLT_st", 1'b0);
        cyc(E_F4, "F4_st", 1'b0);
        cyc(E_DEC, "DEC_st", 1'b0);
        cyc(E_ST1, "ST1_st", 1'b1);
        checkOutput(E_STW, "STW_pre_rst");
        rst = 1'b1;
        applyStimulus(1'b1);
        checkOutput(E_RST, "rst_midstw");
        rst = 1'b0;
        applyStimulus(1'b1);

        // Random instructions with random operands and waits.
        for (int i = 0; i < 60; i++) begin
            runInstr(2'($urandom_range(0, 3)), rnd(),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        checkOutput(E_F1, "final_F1");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
